// File: rtl/wfg_stim_ramp_top.sv
// Wishbone-configured ramp stimulus generator with an AXI-Stream sample output.
// It produces a sawtooth (wrap to START) or a triangle (bounce between START and LIMIT).
// Every value advances only on a stream handshake.
module wfg_stim_ramp_top #(
    parameter int unsigned BUSW = 32,
    parameter int unsigned DATW = 32
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [BUSW-1:0] wbs_dat_i,
    input  logic [BUSW-1:0] wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [BUSW-1:0] wbs_dat_o,
    input  logic            wfg_axis_tready_i,
    output logic            wfg_axis_tvalid_o,
    output logic [DATW-1:0] wfg_axis_tdata_o
);

    typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

    localparam logic [3:0] AdrCtrl  = 4'h0;
    localparam logic [3:0] AdrStart = 4'h4;
    localparam logic [3:0] AdrStep  = 4'h8;
    localparam logic [3:0] AdrLimit = 4'hC;

    logic            wb_req;
    logic            ack_q, ack_d;
    logic [BUSW-1:0] rdat_q, rdat_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic [DATW-1:0] start_q, start_d;
    logic [DATW-1:0] step_q, step_d;
    logic [DATW-1:0] limit_q, limit_d;
    logic [DATW-1:0] cur_q, cur_d;
    state_e          state_q, state_d;

    logic            en, mode;
    logic            tvalid;
    logic            hs;
    logic [DATW:0]   sum_up;
    logic [DATW:0]   floor_dn;
    logic [DATW:0]   cur_x;
    logic [DATW:0]   limit_x;

    // Byte select, upper address bits and upper data bits carry no meaning here.
    logic unused_bus;
    assign unused_bus = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

    assign en       = ctrl_q[0];
    assign mode     = ctrl_q[1];
    assign wb_req   = wbs_stb_i && wbs_cyc_i && !ack_q;
    assign hs       = tvalid && wfg_axis_tready_i;

    // One extra bit so that the sum and the lower turn-around bound never wrap.
    assign cur_x    = {1'b0, cur_q};
    assign limit_x  = {1'b0, limit_q};
    assign sum_up   = cur_x + {1'b0, step_q};
    assign floor_dn = {1'b0, start_q} + {1'b0, step_q};

    // Register file decode: single-cycle ack, registered read data, write on the ack edge.
    always_comb begin
        ack_d   = wb_req;
        rdat_d  = '0;
        ctrl_d  = ctrl_q;
        start_d = start_q;
        step_d  = step_q;
        limit_d = limit_q;
        if (wb_req) begin
            case (wbs_adr_i[3:0])
                AdrCtrl: begin
                    rdat_d[1:0] = ctrl_q;
                    if (wbs_we_i) ctrl_d = wbs_dat_i[1:0];
                end
                AdrStart: begin
                    rdat_d[DATW-1:0] = start_q;
                    if (wbs_we_i) start_d = wbs_dat_i[DATW-1:0];
                end
                AdrStep: begin
                    rdat_d[DATW-1:0] = step_q;
                    if (wbs_we_i) step_d = wbs_dat_i[DATW-1:0];
                end
                AdrLimit: begin
                    rdat_d[DATW-1:0] = limit_q;
                    if (wbs_we_i) limit_d = wbs_dat_i[DATW-1:0];
                end
                default: ;
            endcase
        end
    end

    // Bus-side registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            rdat_q  <= '0;
            ctrl_q  <= '0;
            start_q <= '0;
            step_q  <= '0;
            limit_q <= '0;
        end else begin
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
            ctrl_q  <= ctrl_d;
            start_q <= start_d;
            step_q  <= step_d;
            limit_q <= limit_d;
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: clearing EN always wins; direction changes only on a handshake.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: state_d = StUp;
                StUp: begin
                    if (hs && mode && (sum_up >= limit_x)) state_d = StDown;
                end
                StDown: begin
                    // With MODE cleared the down leg behaves as up and returns there.
                    if (hs && (!mode || (cur_x <= floor_dn))) state_d = StUp;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: EN gates tvalid so a stop takes effect right after the CTRL write.
    always_comb begin
        tvalid = en && (state_q != StIdle);
    end

    // Current value: loads START on start-up, otherwise advances on handshakes only.
    always_comb begin
        cur_d = cur_q;
        if (state_q == StIdle) begin
            if (en) cur_d = start_q;
        end else if (hs) begin
            if (!mode) begin
                cur_d = (sum_up > limit_x) ? start_q : sum_up[DATW-1:0];
            end else if (state_q == StUp) begin
                cur_d = (sum_up >= limit_x) ? limit_q : sum_up[DATW-1:0];
            end else begin
                cur_d = (cur_x <= floor_dn) ? start_q : (cur_q - step_q);
            end
        end
    end

    // Sample register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cur_q <= '0;
        end else begin
            cur_q <= cur_d;
        end
    end

    assign wbs_ack_o         = ack_q;
    assign wbs_dat_o         = rdat_q;
    assign wfg_axis_tvalid_o = tvalid;
    assign wfg_axis_tdata_o  = cur_q;

endmodule

// File: tb/tb_wfg_stim_ramp_top.sv
// Scoreboard bench for wfg_stim_ramp_top: expected samples are queued from a
// reference model and popped by a monitor on every stream handshake.
module tb_wfg_stim_ramp_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic        tready;
    logic        tvalid;
    logic [31:0] tdata;

    int          checks = 0;
    int          errors = 0;
    longint      exp_q[$];
    bit          rand_ready = 1'b0;
    bit          held_valid = 1'b0;
    logic [31:0] held_data;

    always #5 clk = ~clk;

    wfg_stim_ramp_top #(.BUSW(32), .DATW(32)) dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst),
        .wbs_stb_i         (stb),
        .wbs_cyc_i         (cyc),
        .wbs_we_i          (we),
        .wbs_sel_i         (sel),
        .wbs_dat_i         (dat_i),
        .wbs_adr_i         (adr),
        .wbs_ack_o         (ack),
        .wbs_dat_o         (dat_o),
        .wfg_axis_tready_i (tready),
        .wfg_axis_tvalid_o (tvalid),
        .wfg_axis_tdata_o  (tdata)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: next ramp value from the current value and direction (down = 1).
    function automatic void ref_next(input longint c, input bit dn, input longint s,
                                     input longint st, input longint lim, input bit mode,
                                     output longint nc, output bit ndn);
        if (!mode) begin
            ndn = 1'b0;
            nc  = (c + st > lim) ? s : c + st;
        end else if (!dn) begin
            ndn = (c + st >= lim);
            nc  = ndn ? lim : c + st;
        end else begin
            ndn = !(c <= s + st);
            nc  = ndn ? c - st : s;
        end
    endfunction

    task automatic push_seq(input longint s, input longint st, input longint lim,
                            input bit mode, input int n);
        longint c = s;
        bit     dn = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(c);
            ref_next(c, dn, s, st, lim, mode, c, dn);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; dat_i = d;
        @(posedge clk); #1;
        chk("wr_ack", longint'(ack), 1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("wr_ack_one_cycle", longint'(ack), 0);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a;
        @(posedge clk); #1;
        chk("rd_ack", longint'(ack), 1);
        d = dat_o;
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        chk("rd_ack_one_cycle", longint'(ack), 0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clk);
        chk("drain_left", longint'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    // Full run: configure, queue expectations, enable, drain, stop.
    task automatic run_stream(input logic [31:0] s, input logic [31:0] st,
                              input logic [31:0] lim, input bit mode, input bit rr,
                              input int n);
        rand_ready = rr;
        wb_write(32'h4, s);
        wb_write(32'h8, st);
        wb_write(32'hC, lim);
        push_seq(longint'(s), longint'(st), longint'(lim), mode, n);
        wb_write(32'h0, {30'd0, mode, 1'b1});
        drain(n * 12 + 20);
        wb_write(32'h0, 32'h0);
        chk("stop_tvalid", longint'(tvalid), 0);
        rand_ready = 1'b0;
    endtask

    // Downstream ready: always high, or random when backpressure is requested.
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare on handshakes, and check stability across stalls.
    always @(negedge clk) begin
        if (tvalid) begin
            if (held_valid) chk("stall_stable", longint'(tdata), longint'(held_data));
            if (tready) begin
                held_valid = 1'b0;
                if (exp_q.size() > 0) chk("sample", longint'(tdata), exp_q.pop_front());
            end else begin
                held_valid = 1'b1;
                held_data  = tdata;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    initial begin
        logic [31:0] rd;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF; dat_i = '0; adr = '0;
        #1;
        chk("rst_tvalid", longint'(tvalid), 0);
        chk("rst_tdata", longint'(tdata), 0);
        chk("rst_ack", longint'(ack), 0);
        chk("rst_dat", longint'(dat_o), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Register access and unmapped offsets.
        wb_write(32'h4, 32'd5);
        wb_write(32'h8, 32'd3);
        wb_write(32'hC, 32'd20);
        wb_read(32'h4, rd);  chk("rd_start", longint'(rd), 5);
        wb_read(32'h8, rd);  chk("rd_step", longint'(rd), 3);
        wb_read(32'hC, rd);  chk("rd_limit", longint'(rd), 20);
        wb_read(32'h10, rd); chk("rd_0x10", longint'(rd), 0);
        wb_write(32'h2, 32'hFFFF_FFFF);
        wb_read(32'h2, rd);  chk("rd_unmapped", longint'(rd), 0);

        // Sawtooth, triangle, backpressure, overflow, restart.
        run_stream(32'd5, 32'd3, 32'd20, 1'b0, 1'b0, 14);
        run_stream(32'd0, 32'd4, 32'd10, 1'b1, 1'b0, 14);
        run_stream(32'd5, 32'd3, 32'd20, 1'b0, 1'b1, 20);
        run_stream(32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 5);
        run_stream(32'd5, 32'd3, 32'd20, 1'b0, 1'b0, 4);

        // Random configurations, including STEP = 0 and LIMIT < START.
        for (int k = 0; k < 8; k++) begin
            run_stream(32'($urandom_range(0, 50)), 32'($urandom_range(0, 9)),
                       32'($urandom_range(0, 80)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 16);
        end

        // Asynchronous reset mid-stream.
        wb_write(32'h4, 32'd7);
        wb_write(32'h8, 32'd2);
        wb_write(32'hC, 32'd40);
        push_seq(64'd7, 64'd2, 64'd40, 1'b0, 60);
        wb_write(32'h0, 32'h1);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tvalid", longint'(tvalid), 0);
        chk("midrst_tdata", longint'(tdata), 0);
        chk("midrst_ack", longint'(ack), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("post_rst_idle", longint'(tvalid), 0);
        wb_read(32'h4, rd); chk("post_rst_start", longint'(rd), 0);
        wb_read(32'h0, rd); chk("post_rst_ctrl", longint'(rd), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
